// File: rtl/mips_pkg.sv
// Shared pipeline definitions: forwarding encoding, scoreboard entry layout
// and the saturation limit used by the performance counters.
package mips_pkg;

    // Entry dst field is sized for the widest register address in use; narrower
    // addresses are zero-extended by the scoreboard before comparison.
    localparam int unsigned SB_ADDR_MAX = 16;
    localparam int unsigned FWD_NONE    = 0;
    localparam logic [31:0] CNT_SAT     = 32'hFFFF_FFFF;

    typedef struct packed {
        logic                   valid;
        logic [SB_ADDR_MAX-1:0] dst;
        logic                   wb_en;
        logic                   is_load;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Per-source dependency check: finds the youngest in-flight producer of one
// source register and decides between stalling and forwarding from it.
module sb_match
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned FWD_EN   = 0,
    parameter int unsigned LOAD_LAT = 1
) (
    input  sb_entry_t [DEPTH-1:0]        entries_i,
    input  logic [SB_ADDR_MAX-1:0]       src_i,
    input  logic                         used_i,
    output logic                         stall_o,
    output logic [$clog2(DEPTH+1)-1:0]   sel_o
);

    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    logic             hit;
    logic             load_blocks;
    logic [SEL_W-1:0] idx;

    always_comb begin
        hit         = 1'b0;
        load_blocks = 1'b0;
        idx         = '0;
        // Scan from EXE outward; the first hit is the youngest producer.
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!hit && used_i && (src_i != '0) && entries_i[k].valid &&
                entries_i[k].wb_en && (entries_i[k].dst == src_i)) begin
                hit         = 1'b1;
                idx         = SEL_W'(k);
                load_blocks = entries_i[k].is_load && (k < LOAD_LAT);
            end
        end
    end

    always_comb begin
        stall_o = 1'b0;
        sel_o   = SEL_W'(FWD_NONE);
        if (FWD_EN == 0) begin
            stall_o = hit;
        end else begin
            stall_o = hit && load_blocks;
            if (hit && !load_blocks) begin
                sel_o = idx + SEL_W'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks in-flight destinations between ID and WB and
// produces the ID stall and per-operand forwarding selects, plus perf counters.
module hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned FWD_EN     = 0,
    parameter int unsigned LOAD_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [REG_ADDR_W-1:0]       src1,
    input  logic [REG_ADDR_W-1:0]       src2,
    input  logic                        src2_used,
    input  logic [REG_ADDR_W-1:0]       id_dst,
    input  logic                        id_wb_en,
    input  logic                        id_mem_read,
    input  logic                        flush,
    output logic                        stall,
    output logic [$clog2(DEPTH+1)-1:0]  fwd_sel1,
    output logic [$clog2(DEPTH+1)-1:0]  fwd_sel2,
    output logic [31:0]                 stall_cnt,
    output logic [31:0]                 fwd_cnt
);

    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [31:0]           stall_cnt_q, stall_cnt_d;
    logic [31:0]           fwd_cnt_q, fwd_cnt_d;

    logic             raw1, raw2;
    logic [SEL_W-1:0] sel1_raw, sel2_raw;
    logic [1:0]       fwd_inc;
    logic [32:0]      fwd_sum;

    sb_match #(
        .DEPTH    (DEPTH),
        .FWD_EN   (FWD_EN),
        .LOAD_LAT (LOAD_LAT)
    ) u_match1 (
        .entries_i (entries_q),
        .src_i     (SB_ADDR_MAX'(src1)),
        .used_i    (1'b1),
        .stall_o   (raw1),
        .sel_o     (sel1_raw)
    );

    sb_match #(
        .DEPTH    (DEPTH),
        .FWD_EN   (FWD_EN),
        .LOAD_LAT (LOAD_LAT)
    ) u_match2 (
        .entries_i (entries_q),
        .src_i     (SB_ADDR_MAX'(src2)),
        .used_i    (src2_used),
        .stall_o   (raw2),
        .sel_o     (sel2_raw)
    );

    // Flush and reset both override a hazard; a stall cycle forwards nothing.
    always_comb begin
        stall    = (raw1 || raw2) && id_valid && !flush && !rst;
        fwd_sel1 = SEL_W'(FWD_NONE);
        fwd_sel2 = SEL_W'(FWD_NONE);
        if (id_valid && !stall && !rst) begin
            fwd_sel1 = sel1_raw;
            fwd_sel2 = sel2_raw;
        end
    end

    always_comb begin
        entries_d = '0;
        if (!stall && !flush) begin
            entries_d[0] = '{valid:   id_valid,
                             dst:     SB_ADDR_MAX'(id_dst),
                             wb_en:   id_wb_en,
                             is_load: id_mem_read};
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            entries_d[k] = entries_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_SAT)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        fwd_inc   = {1'b0, fwd_sel1 != '0} + {1'b0, fwd_sel2 != '0};
        fwd_sum   = {1'b0, fwd_cnt_q} + 33'(fwd_inc);
        fwd_cnt_d = fwd_sum[32] ? CNT_SAT : fwd_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q   <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            entries_q   <= entries_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a stall-only DEPTH=2 unit and a forwarding
// DEPTH=3 unit share stimulus and are checked against a queue-based model.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, src2_used, id_wb_en, id_mem_read, flush;
    logic [4:0] src1, src2, id_dst;

    logic        a_stall, b_stall;
    logic [1:0]  a_sel1, a_sel2, b_sel1, b_sel2;
    logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;

    hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(2), .FWD_EN(0), .LOAD_LAT(1)) d0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .src2_used(src2_used), .id_dst(id_dst), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .flush(flush), .stall(a_stall),
        .fwd_sel1(a_sel1), .fwd_sel2(a_sel2), .stall_cnt(a_scnt), .fwd_cnt(a_fcnt)
    );

    hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(3), .FWD_EN(1), .LOAD_LAT(1)) d1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .src2_used(src2_used), .id_dst(id_dst), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .flush(flush), .stall(b_stall),
        .fwd_sel1(b_sel1), .fwd_sel2(b_sel2), .stall_cnt(b_scnt), .fwd_cnt(b_fcnt)
    );

    typedef struct {
        bit v;
        int dst;
        bit wb;
        bit ld;
    } ent_t;

    localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

    // Model pipeline: index 0 is the youngest in-flight instruction (EXE).
    ent_t   q0[$], q1[$];
    longint c0s, c0f, c1s, c1f;
    int     n_pass = 0, n_chk = 0;

    function automatic ent_t bubble();
        ent_t e;
        e.v = 0; e.dst = 0; e.wb = 0; e.ld = 0;
        return e;
    endfunction

    function automatic int youngest(input ent_t q[$], input int s, input bit used);
        if (!used || s == 0) return -1;
        foreach (q[k]) if (q[k].v && q[k].wb && q[k].dst == s) return k;
        return -1;
    endfunction

    function automatic void model_eval(input ent_t q[$], input bit fwd,
                                       output bit st, output int s1, output int s2);
        int k1, k2;
        bit r1, r2;
        k1 = youngest(q, int'(src1), 1'b1);
        k2 = youngest(q, int'(src2), src2_used);
        r1 = (k1 >= 0) && (!fwd || (q[k1].ld && k1 < 1));
        r2 = (k2 >= 0) && (!fwd || (q[k2].ld && k2 < 1));
        st = (r1 || r2) && id_valid && !flush && !rst;
        s1 = (fwd && k1 >= 0 && !r1 && !st && id_valid && !rst) ? k1 + 1 : 0;
        s2 = (fwd && k2 >= 0 && !r2 && !st && id_valid && !rst) ? k2 + 1 : 0;
    endfunction

    function automatic ent_t incoming(input bit st);
        ent_t e;
        e = bubble();
        if (!st && !flush) begin
            e.v = id_valid; e.dst = int'(id_dst); e.wb = id_wb_en; e.ld = id_mem_read;
        end
        return e;
    endfunction

    task automatic adv();
        bit st0, st1;
        int x1, x2, y1, y2;
        model_eval(q0, 1'b0, st0, x1, x2);
        model_eval(q1, 1'b1, st1, y1, y2);
        @(posedge clk);
        if (rst) begin
            foreach (q0[k]) q0[k] = bubble();
            foreach (q1[k]) q1[k] = bubble();
            c0s = 0; c0f = 0; c1s = 0; c1f = 0;
        end else begin
            q0.push_front(incoming(st0)); void'(q0.pop_back());
            q1.push_front(incoming(st1)); void'(q1.pop_back());
            if (st0 && c0s < SAT) c0s++;
            if (st1 && c1s < SAT) c1s++;
            c0f += int'(x1 != 0) + int'(x2 != 0); if (c0f > SAT) c0f = SAT;
            c1f += int'(y1 != 0) + int'(y2 != 0); if (c1f > SAT) c1f = SAT;
        end
        #1;
    endtask

    task automatic put(input bit v, input int s1, input int s2, input bit u2,
                       input int d, input bit wb, input bit ld, input bit fl);
        id_valid = v; src1 = 5'(s1); src2 = 5'(s2); src2_used = u2;
        id_dst = 5'(d); id_wb_en = wb; id_mem_read = ld; flush = fl;
    endtask

    task automatic do_reset();
        put(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        adv();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++; if (a_stall !== 1'b0) $display("FAIL reset_stall got=%0b exp=0", a_stall); else n_pass++;
        n_chk++; if (a_scnt !== 32'd0) $display("FAIL reset_scnt0 got=%0d exp=0", a_scnt); else n_pass++;
        n_chk++; if (b_fcnt !== 32'd0) $display("FAIL reset_fcnt1 got=%0d exp=0", b_fcnt); else n_pass++;
    endtask

    task automatic test_stall_only();
        do_reset();
        put(1, 1, 2, 1, 3, 1, 0, 0); #1;
        n_chk++; if (a_stall !== 1'b0) $display("FAIL so_first got=%0b exp=0", a_stall); else n_pass++;
        adv();
        put(1, 3, 5, 1, 4, 1, 0, 0); #1;
        n_chk++; if (a_stall !== 1'b1) $display("FAIL so_stall1 got=%0b exp=1", a_stall); else n_pass++;
        adv(); #1;
        n_chk++; if (a_stall !== 1'b1) $display("FAIL so_stall2 got=%0b exp=1", a_stall); else n_pass++;
        adv(); #1;
        n_chk++; if (a_stall !== 1'b0) $display("FAIL so_release got=%0b exp=0", a_stall); else n_pass++;
        n_chk++; if (a_sel1 !== 2'd0) $display("FAIL so_sel1 got=%0d exp=0", a_sel1); else n_pass++;
        n_chk++; if (a_scnt !== 32'd2) $display("FAIL so_scnt got=%0d exp=2", a_scnt); else n_pass++;
    endtask

    task automatic test_load_fwd();
        do_reset();
        put(1, 0, 0, 0, 3, 1, 1, 0);
        adv();
        put(1, 3, 3, 1, 4, 1, 0, 0); #1;
        n_chk++; if (b_stall !== 1'b1) $display("FAIL lw_stall got=%0b exp=1", b_stall); else n_pass++;
        adv(); #1;
        n_chk++; if (b_stall !== 1'b0) $display("FAIL lw_release got=%0b exp=0", b_stall); else n_pass++;
        n_chk++; if (b_sel1 !== 2'd2) $display("FAIL lw_sel1 got=%0d exp=2", b_sel1); else n_pass++;
        n_chk++; if (b_sel2 !== 2'd2) $display("FAIL lw_sel2 got=%0d exp=2", b_sel2); else n_pass++;
        adv();
        id_valid = 1'b0; #1;
        n_chk++; if (b_fcnt !== 32'd2) $display("FAIL lw_fcnt got=%0d exp=2", b_fcnt); else n_pass++;
        n_chk++; if (b_scnt !== 32'd1) $display("FAIL lw_scnt got=%0d exp=1", b_scnt); else n_pass++;
    endtask

    task automatic test_youngest();
        do_reset();
        put(1, 1, 1, 1, 3, 1, 0, 0); adv();
        put(1, 2, 2, 1, 3, 1, 0, 0); adv();
        put(1, 3, 3, 0, 5, 1, 0, 0); #1;
        n_chk++; if (b_sel1 !== 2'd1) $display("FAIL yg_sel1 got=%0d exp=1", b_sel1); else n_pass++;
        n_chk++; if (b_sel2 !== 2'd0) $display("FAIL yg_unused_sel2 got=%0d exp=0", b_sel2); else n_pass++;
        n_chk++; if (b_stall !== 1'b0) $display("FAIL yg_stall got=%0b exp=0", b_stall); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        put(1, 0, 0, 0, 3, 1, 0, 0); adv();
        put(1, 3, 0, 0, 4, 1, 0, 1); #1;
        n_chk++; if (a_stall !== 1'b0) $display("FAIL fl_stall got=%0b exp=0", a_stall); else n_pass++;
        adv();
        flush = 1'b0; #1;
        n_chk++; if (b_sel1 !== 2'd2) $display("FAIL fl_bubble_sel1 got=%0d exp=2", b_sel1); else n_pass++;
    endtask

    task automatic test_r0();
        do_reset();
        put(1, 1, 1, 1, 0, 1, 0, 0); adv();
        put(1, 0, 0, 1, 6, 1, 0, 0); #1;
        n_chk++; if (a_stall !== 1'b0) $display("FAIL r0_stall0 got=%0b exp=0", a_stall); else n_pass++;
        n_chk++; if (b_stall !== 1'b0) $display("FAIL r0_stall1 got=%0b exp=0", b_stall); else n_pass++;
        n_chk++; if ({b_sel1, b_sel2} !== 4'd0) $display("FAIL r0_sel got=%0d/%0d exp=0/0", b_sel1, b_sel2); else n_pass++;
    endtask

    task automatic test_saturate();
        int t;
        do_reset();
        force d0.stall_cnt_q = 32'hFFFF_FFFD;
        c0s = 64'hFFFF_FFFD;
        #1 release d0.stall_cnt_q;
        put(1, 3, 0, 0, 3, 1, 0, 0);
        repeat (8) adv();
        #1;
        n_chk++; if (a_scnt !== 32'hFFFF_FFFF) $display("FAIL sat_hold got=%h exp=ffffffff", a_scnt); else n_pass++;
        n_chk++; if (longint'(a_scnt) !== c0s) $display("FAIL sat_model got=%h exp=%h", a_scnt, c0s); else n_pass++;
        t = 0;
        while (a_stall !== 1'b1 && t < 10) begin adv(); t++; end
        n_chk++; if (a_stall !== 1'b1) $display("FAIL sat_wait_stall got=%0b exp=1", a_stall); else n_pass++;
        rst = 1'b1; #1;
        n_chk++; if (a_stall !== 1'b0) $display("FAIL rst_mid_stall got=%0b exp=0", a_stall); else n_pass++;
        n_chk++; if ({b_stall, b_sel1, b_sel2} !== 5'd0) $display("FAIL rst_fwd_outs got=%0b/%0d/%0d exp=0/0/0", b_stall, b_sel1, b_sel2); else n_pass++;
        adv();
        rst = 1'b0; id_valid = 1'b0; #1;
        n_chk++; if ({a_scnt, a_fcnt} !== 64'd0) $display("FAIL rst_cnt0 got=%h/%h exp=0/0", a_scnt, a_fcnt); else n_pass++;
        n_chk++; if ({b_scnt, b_fcnt} !== 64'd0) $display("FAIL rst_cnt1 got=%h/%h exp=0/0", b_scnt, b_fcnt); else n_pass++;
    endtask

    task automatic test_random();
        bit st;
        int e1, e2;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            id_valid    = ($urandom_range(0, 4) != 0);
            src1        = 5'($urandom_range(0, 3));
            src2        = 5'($urandom_range(0, 3));
            src2_used   = 1'($urandom);
            id_dst      = 5'($urandom_range(0, 3));
            id_wb_en    = ($urandom_range(0, 3) != 0);
            id_mem_read = 1'($urandom);
            flush       = ($urandom_range(0, 9) == 0);
            #1;
            model_eval(q0, 1'b0, st, e1, e2);
            n_chk++; if (a_stall !== st) $display("FAIL rnd_stall0 i=%0d got=%0b exp=%0b", i, a_stall, st); else n_pass++;
            n_chk++; if ({a_sel1, a_sel2} !== 4'd0) $display("FAIL rnd_sel0 i=%0d got=%0d/%0d exp=0/0", i, a_sel1, a_sel2); else n_pass++;
            n_chk++; if (longint'(a_scnt) !== c0s) $display("FAIL rnd_scnt0 i=%0d got=%0d exp=%0d", i, a_scnt, c0s); else n_pass++;
            model_eval(q1, 1'b1, st, e1, e2);
            n_chk++; if (b_stall !== st) $display("FAIL rnd_stall1 i=%0d got=%0b exp=%0b", i, b_stall, st); else n_pass++;
            n_chk++; if (int'(b_sel1) !== e1) $display("FAIL rnd_sel1 i=%0d got=%0d exp=%0d", i, b_sel1, e1); else n_pass++;
            n_chk++; if (int'(b_sel2) !== e2) $display("FAIL rnd_sel2 i=%0d got=%0d exp=%0d", i, b_sel2, e2); else n_pass++;
            n_chk++; if (longint'(b_scnt) !== c1s) $display("FAIL rnd_scnt1 i=%0d got=%0d exp=%0d", i, b_scnt, c1s); else n_pass++;
            n_chk++; if (longint'(b_fcnt) !== c1f) $display("FAIL rnd_fcnt1 i=%0d got=%0d exp=%0d", i, b_fcnt, c1f); else n_pass++;
            adv();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        put(0, 0, 0, 0, 0, 0, 0, 0);
        c0s = 0; c0f = 0; c1s = 0; c1f = 0;
        repeat (2) q0.push_back(bubble());
        repeat (3) q1.push_back(bubble());
        test_reset();
        test_stall_only();
        test_load_fwd();
        test_youngest();
        test_flush();
        test_r0();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
